spi_cmd_dispatch: RTL

// Downstream consumer of the SPI slave frame interface. Takes each received 32-bit frame
// (opcode in [7:0], byte0 [15:8], byte1 [23:16], byte2 [31:24]) and runs register

---
 rtl/spi_cmd_dispatch_pkg.sv | 21 ++
 rtl/spi_cmd_dispatch.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spi_cmd_dispatch_pkg.sv
// Shared opcode, reply-status and FSM state definitions for the SPI command dispatcher.
package spi_cmd_dispatch_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_INIT  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADOP   = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT = 8'hE2;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StBusWr,
    StBusRd,
    StResp
  } state_e;

endpackage

// File: rtl/spi_cmd_dispatch.sv
// Turns received SPI frames into register-bus read/write transactions and queues
// 24-bit replies (read data or error status) for the next SPI frame.
module spi_cmd_dispatch
  import spi_cmd_dispatch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rd_data_available,
  input  logic [31:0]       i_rd_data,
  output logic              o_rd_ack,
  input  logic              i_wr_buffer_free,
  output logic              o_wr_en,
  output logic [DATA_W+7:0] o_wr_data,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_reg_wdata,
  output logic              o_reg_we,
  output logic              o_reg_re,
  input  logic [DATA_W-1:0] i_reg_rdata,
  input  logic              i_reg_ready,
  output logic              o_busy,
  output logic [15:0]       o_cmd_count,
  output logic [7:0]        o_err_count
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e              r_state;
  logic                r_armed;
  logic [31:0]         r_frame;
  logic [7:0]          r_tcount;
  logic [DATA_W+7:0]   r_reply;
  logic                r_rd_ack;
  logic                r_wr_en;
  logic [DATA_W+7:0]   r_wr_data;
  logic [ADDR_W-1:0]   r_reg_addr;
  logic [DATA_W-1:0]   r_reg_wdata;
  logic                r_reg_we;
  logic                r_reg_re;
  logic [15:0]         r_cmd_count;
  logic [7:0]          r_err_count;
  logic [7:0]          w_err_inc;

  assign w_err_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_armed     <= 1'b1;
      r_frame     <= '0;
      r_tcount    <= '0;
      r_reply     <= '0;
      r_rd_ack    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
      r_cmd_count <= '0;
      r_err_count <= '0;
    end else begin
      r_rd_ack <= 1'b0;
      r_wr_en  <= 1'b0;
      // The slave holds the flag until its next frame boundary; re-arm only once it drops.
      if (!i_rd_data_available) r_armed <= 1'b1;

      case (r_state)
        StIdle: begin
          if (i_rd_data_available && r_armed) begin
            r_frame     <= i_rd_data;
            r_rd_ack    <= 1'b1;
            r_armed     <= 1'b0;
            r_cmd_count <= r_cmd_count + 16'd1;
            r_state     <= StDecode;
          end
        end
        StDecode: begin
          r_tcount <= '0;
          case (r_frame[7:0])
            OP_NOP, OP_INIT: r_state <= StIdle;
            OP_WRITE: begin
              r_reg_addr  <= r_frame[8 +: ADDR_W];
              r_reg_wdata <= r_frame[31:16];
              r_reg_we    <= 1'b1;
              r_state     <= StBusWr;
            end
            OP_READ: begin
              r_reg_addr <= r_frame[8 +: ADDR_W];
              r_reg_re   <= 1'b1;
              r_state    <= StBusRd;
            end
            default: begin
              r_err_count <= w_err_inc;
              r_reply     <= {{DATA_W{1'b0}}, ST_BADOP};
              r_state     <= StResp;
            end
          endcase
        end
        StBusWr, StBusRd: begin
          // Ready is checked before the timeout so a completion on the last cycle wins.
          if (i_reg_ready) begin
            r_reg_we <= 1'b0;
            r_reg_re <= 1'b0;
            if (r_state == StBusRd) begin
              r_reply <= {i_reg_rdata, ST_OK};
              r_state <= StResp;
            end else begin
              r_state <= StIdle;
            end
          end else if (r_tcount == TO_LAST) begin
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_err_count <= w_err_inc;
            r_reply     <= {{DATA_W{1'b0}}, ST_TIMEOUT};
            r_state     <= StResp;
          end else begin
            r_tcount <= r_tcount + 8'd1;
          end
        end
        StResp: begin
          if (i_wr_buffer_free) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= r_reply;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rd_ack    = r_rd_ack;
  assign o_wr_en     = r_wr_en;
  assign o_wr_data   = r_wr_data;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_reg_we    = r_reg_we;
  assign o_reg_re    = r_reg_re;
  assign o_busy      = (r_state != StIdle);
  assign o_cmd_count = r_cmd_count;
  assign o_err_count = r_err_count;

endmodule
